// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the M-stage load/store interface.
// Every access takes LATENCY wait cycles before it completes, and stallM
// holds the pipeline until then. The word read or write happens at
// completion, and ackM pulses for that one cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   memreqM     M-stage instruction performs a load or store
//   memwriteM   1 = store, 0 = load (valid with memreqM)
//   aluoutM     byte address; word index = aluoutM[log2(DEPTH_WORDS)+1:2]
//   writedataM  store data
//   readdataM   registered load data, held until the next completed load
//   stallM      combinational hold request to the hazard unit
//   ackM        one-cycle completion pulse (registered)
//   misalignM   completion of a misaligned access, pulses with ackM
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        ackM,
    output logic        misalignM
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] nextWaitCnt;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] wordIdx;
    logic             aligned;
    logic             enterDone;
    logic             unusedAddrBits;

    // Upper address bits are ignored: addresses alias modulo DEPTH_WORDS*4.
    assign wordIdx        = aluoutM[IDX_W+1:2];
    assign aligned        = (aluoutM[1:0] == 2'b00);
    assign unusedAddrBits = ^aluoutM[31:IDX_W+2];

    // DONE is the only cycle in which a pending request is not held.
    assign stallM    = memreqM & (state != DONE);
    assign enterDone = (nextState == DONE);

    // Next-state and wait-counter logic.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            IDLE: begin
                if (memreqM) begin
                    nextWaitCnt = LAT;
                    nextState   = (LATENCY == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!memreqM) begin
                    // Flushed while waiting: abandon the access silently.
                    nextState   = IDLE;
                    nextWaitCnt = '0;
                end else begin
                    nextWaitCnt = waitCnt - CNT_W'(1);
                    if (waitCnt <= CNT_W'(1)) begin
                        nextState = DONE;
                    end
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Completion flags and load data, updated on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdataM <= '0;
            ackM      <= 1'b0;
            misalignM <= 1'b0;
        end else begin
            ackM      <= enterDone;
            misalignM <= enterDone & ~aligned;
            if (enterDone && !memwriteM) begin
                readdataM <= aligned ? mem[wordIdx] : '0;
            end
        end
    end

    // Stores commit on the edge leaving DONE; reset on that edge cancels them.
    always_ff @(posedge clk) begin
        if (!reset && state == DONE && memreqM && memwriteM && aligned) begin
            mem[wordIdx] <= writedataM;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        req0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rd, rd0;
    logic        stall, ack, mis, stall0, ack0, mis0;

    int vecs = 0;
    int errs = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
    } expT;
    expT expQ[$];

    int          sc, ac, an;
    logic [31:0] ro;
    logic        mo;
    expT         e;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .memreqM(req), .memwriteM(wr),
        .aluoutM(addr), .writedataM(wdata), .readdataM(rd),
        .stallM(stall), .ackM(ack), .misalignM(mis)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .memreqM(req0), .memwriteM(wr0),
        .aluoutM(addr0), .writedataM(wdata0), .readdataM(rd0),
        .stallM(stall0), .ackM(ack0), .misalignM(mis0)
    );

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dropReq();
        req = 1'b0; wr = 1'b0; req0 = 1'b0; wr0 = 1'b0;
    endtask

    // Present one request (caller is just past a rising edge) and hold it
    // until stall drops; returns just past the edge that ends the access.
    task automatic doAccess(input bit sel, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output int stallCyc,
                            output int ackCyc, output int ackCnt,
                            output logic [31:0] rdObs, output logic misObs);
        stallCyc = 0; ackCyc = -1; ackCnt = 0; rdObs = 'x; misObs = 1'bx;
        if (sel) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
        else     begin req  = 1'b1; wr  = w; addr  = a; wdata  = d; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sel ? ack0 : ack) begin
                ackCnt++;
                if (ackCyc < 0) begin
                    ackCyc = c;
                    rdObs  = sel ? rd0 : rd;
                    misObs = sel ? mis0 : mis;
                end
            end
            if (sel ? stall0 : stall) stallCyc++;
            else break;
        end
        nextCycle();
    endtask

    task automatic test_reset();
        repeat (3) nextCycle();
        req = 1'b1;
        @(negedge clk);
        vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL rst_stall_follows_req: got %b want 1", stall); end
        vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL rst_ack: got %b want 0", ack); end
        vecs++; if (mis !== 1'b0) begin errs++; $display("FAIL rst_mis: got %b want 0", mis); end
        vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL rst_rd: got %h want 0", rd); end
        nextCycle();
        req = 1'b0; reset = 1'b0;
        @(negedge clk);
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall_idle: got %b want 0", stall); end
        vecs++; if (ack0 !== 1'b0) begin errs++; $display("FAIL rst_ack0: got %b want 0", ack0); end
        nextCycle();
    endtask

    task automatic test_store_load();
        // A store leaves readdataM at its reset value.
        expQ.push_back('{32'h0, 1'b0});
        doAccess(0, 1'b1, 32'h10, 32'hDEADBEEF, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (sc !== 3) begin errs++; $display("FAIL st_stall_cycles: got %0d want 3", sc); end
        vecs++; if (ac !== 3) begin errs++; $display("FAIL st_ack_cycle: got %0d want 3", ac); end
        vecs++; if (an !== 1) begin errs++; $display("FAIL st_ack_count: got %0d want 1", an); end
        vecs++; if (mo !== e.mis) begin errs++; $display("FAIL st_mis: got %b want %b", mo, e.mis); end
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL st_rd_unchanged: got %h want %h", ro, e.rd); end
        dropReq();
        @(negedge clk);
        vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL st_ack_cycle4: got %b want 0", ack); end
        nextCycle();

        expQ.push_back('{32'hDEADBEEF, 1'b0});
        doAccess(0, 1'b0, 32'h10, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (ac !== 3) begin errs++; $display("FAIL ld_ack_cycle: got %0d want 3", ac); end
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL ld_data: got %h want %h", ro, e.rd); end
        dropReq(); nextCycle();

        expQ.push_back('{32'hDEADBEEF, 1'b0});
        doAccess(0, 1'b0, 32'h110, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL ld_alias: got %h want %h", ro, e.rd); end
        vecs++; if (mo !== e.mis) begin errs++; $display("FAIL ld_alias_mis: got %b want %b", mo, e.mis); end
        dropReq(); nextCycle();
    endtask

    task automatic test_misalign();
        expQ.push_back('{32'hDEADBEEF, 1'b1});
        doAccess(0, 1'b1, 32'h12, 32'h12345678, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (ac !== 3) begin errs++; $display("FAIL mis_st_ack_cycle: got %0d want 3", ac); end
        vecs++; if (mo !== e.mis) begin errs++; $display("FAIL mis_st_flag: got %b want %b", mo, e.mis); end
        dropReq(); nextCycle();

        expQ.push_back('{32'hDEADBEEF, 1'b0});
        doAccess(0, 1'b0, 32'h10, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL mis_st_suppressed: got %h want %h", ro, e.rd); end
        dropReq(); nextCycle();

        expQ.push_back('{32'h0, 1'b1});
        doAccess(0, 1'b0, 32'h13, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL mis_ld_data: got %h want %h", ro, e.rd); end
        vecs++; if (mo !== e.mis) begin errs++; $display("FAIL mis_ld_flag: got %b want %b", mo, e.mis); end
        dropReq(); nextCycle();
    endtask

    task automatic test_back_to_back();
        int extra;
        doAccess(0, 1'b1, 32'h14, 32'h55AA0014, sc, ac, an, ro, mo);
        dropReq(); nextCycle();

        expQ.push_back('{32'hDEADBEEF, 1'b0});
        doAccess(0, 1'b0, 32'h10, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (sc !== 3) begin errs++; $display("FAIL b2b_first_stall: got %0d want 3", sc); end
        vecs++; if (ac !== 3) begin errs++; $display("FAIL b2b_first_ack: got %0d want 3", ac); end
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL b2b_first_data: got %h want %h", ro, e.rd); end
        // Second request presented in the cycle right after the first ack.
        expQ.push_back('{32'h55AA0014, 1'b0});
        doAccess(0, 1'b0, 32'h14, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (sc !== 3) begin errs++; $display("FAIL b2b_second_stall: got %0d want 3", sc); end
        vecs++; if (ac !== 3) begin errs++; $display("FAIL b2b_second_ack (abs cycle 7): got %0d want 3", ac); end
        vecs++; if (an !== 1) begin errs++; $display("FAIL b2b_second_ack_count: got %0d want 1", an); end
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL b2b_second_data: got %h want %h", ro, e.rd); end
        dropReq();
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) extra++;
            nextCycle();
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL b2b_extra_ack: got %0d want 0", extra); end
    endtask

    task automatic test_flush();
        int acks;
        doAccess(0, 1'b1, 32'h30, 32'h30303030, sc, ac, an, ro, mo);
        dropReq(); nextCycle();
        req = 1'b1; wr = 1'b1; addr = 32'h30; wdata = 32'hBAD0BAD0;
        nextCycle();
        dropReq();
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack) acks++;
            nextCycle();
        end
        vecs++; if (acks !== 0) begin errs++; $display("FAIL flush_ack: got %0d want 0", acks); end
        expQ.push_back('{32'h30303030, 1'b0});
        doAccess(0, 1'b0, 32'h30, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL flush_no_write: got %h want %h", ro, e.rd); end
        dropReq(); nextCycle();
    endtask

    task automatic test_reset_abort();
        doAccess(0, 1'b1, 32'h20, 32'h11111111, sc, ac, an, ro, mo);
        dropReq(); nextCycle();
        doAccess(0, 1'b0, 32'h20, 32'h0, sc, ac, an, ro, mo);
        dropReq(); nextCycle();

        // Reset while the store is in WAIT.
        req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0; dropReq();
        @(negedge clk);
        vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL rstwait_ack: got %b want 0", ack); end
        vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL rstwait_rd: got %h want 0", rd); end
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rstwait_stall: got %b want 0", stall); end
        nextCycle();

        // Reset sampled on the edge leaving DONE still cancels the store.
        req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
        repeat (3) nextCycle();
        @(negedge clk);
        vecs++; if (ack !== 1'b1) begin errs++; $display("FAIL rstdone_ack: got %b want 1", ack); end
        reset = 1'b1;
        nextCycle();
        reset = 1'b0; dropReq();
        nextCycle();

        expQ.push_back('{32'h11111111, 1'b0});
        doAccess(0, 1'b0, 32'h20, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL rst_store_cancelled: got %h want %h", ro, e.rd); end
        dropReq(); nextCycle();
    endtask

    task automatic test_latency0();
        int busy;
        busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (stall0 || ack0) busy++;
            nextCycle();
        end
        vecs++; if (busy !== 0) begin errs++; $display("FAIL l0_idle_quiet: got %0d want 0", busy); end

        expQ.push_back('{32'h0, 1'b0});
        doAccess(1, 1'b1, 32'h8, 32'hA5A50008, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (sc !== 1) begin errs++; $display("FAIL l0_st_stall: got %0d want 1", sc); end
        vecs++; if (ac !== 1) begin errs++; $display("FAIL l0_st_ack: got %0d want 1", ac); end
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL l0_st_rd: got %h want %h", ro, e.rd); end
        dropReq(); nextCycle();

        expQ.push_back('{32'hA5A50008, 1'b0});
        doAccess(1, 1'b0, 32'h8, 32'h0, sc, ac, an, ro, mo);
        e = expQ.pop_front();
        vecs++; if (sc !== 1) begin errs++; $display("FAIL l0_ld_stall: got %0d want 1", sc); end
        vecs++; if (ac !== 1) begin errs++; $display("FAIL l0_ld_ack: got %0d want 1", ac); end
        vecs++; if (an !== 1) begin errs++; $display("FAIL l0_ld_ack_count: got %0d want 1", an); end
        vecs++; if (ro !== e.rd) begin errs++; $display("FAIL l0_ld_data: got %h want %h", ro, e.rd); end
        vecs++; if (mo !== e.mis) begin errs++; $display("FAIL l0_ld_mis: got %b want %b", mo, e.mis); end
        dropReq(); nextCycle();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misalign();
        test_back_to_back();
        test_flush();
        test_reset_abort();
        test_latency0();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the pipeline's M-stage load/store interface.
- Samples each access presented in the memory stage and inserts a configurable number of wait states, holding the pipeline with stallM.
- Performs the word read or write, then pulses ackM in the completion cycle.
- Replaces the zero-latency dmem in the top module so the pipeline can be exercised against slow memory.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, 4..4096.
- LATENCY, 2, WAIT-state cycles per access; 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- memreqM  input  1  M-stage instruction performs a load or store.
- memwriteM  input  1  1 = store, 0 = load; valid with memreqM.
- aluoutM  input  32  byte address.
- writedataM  input  32  store data.
- readdataM  output  32  load data, registered.
- stallM  output  1  combinational hold request to the hazard unit.
- ackM  output  1  one-cycle completion pulse.
- misalignM  output  1  completion of a misaligned access; pulses with ackM.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE, wait counter 0, readdataM 0, ackM 0, misalignM 0, stallM = memreqM (combinational).
- Reset does not clear memory contents. Initial contents are undefined.
- Pipeline contract: while stallM=1 the pipeline holds memreqM, memwriteM, aluoutM and writedataM stable.
- FSM states: IDLE, WAIT, DONE.
- IDLE, memreqM=1: load counter with LATENCY. Go to WAIT, or go directly to DONE if LATENCY=0.
- IDLE, memreqM=0: stay in IDLE.
- WAIT: decrement the counter each cycle. Go to DONE on the edge where the counter reaches 0, so WAIT lasts exactly LATENCY cycles.
- DONE: always go to IDLE on the next edge.
- stallM = memreqM & (state != DONE). A request therefore stalls LATENCY+1 cycles and completes in cycle LATENCY+1, counted from cycle 0 = first request cycle.
- ackM and misalignM are registered: asserted exactly during DONE, otherwise 0.
- Word index = aluoutM[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Aligned load: readdataM <= mem[index] on the edge entering DONE. readdataM holds that value until the next completed load.
- Aligned store: mem[index] <= writedataM on the edge leaving DONE. A store leaves readdataM unchanged.
- Misaligned access (aluoutM[1:0] != 0):
  - same timing as an aligned access;
  - a store is suppressed (no memory change);
  - a load sets readdataM to 0;
  - misalignM=1 during DONE.
- Back-to-back accesses: after DONE the FSM always passes through IDLE. A request present in the cycle after DONE is treated as new and incurs the full LATENCY+1 stall; no request is ever double-executed.
- memreqM deasserted during WAIT (flush): abort, return to IDLE on the next edge, no write, no ack.
- Reset during WAIT or DONE: IDLE on the next edge. A pending store is not performed, even if reset is sampled on the edge leaving DONE.
- memwriteM is ignored when memreqM=0.

Test Plan:
1. LATENCY=2. Store 0xDEADBEEF to 0x10 (request held from cycle 0) -> stallM=1 in cycles 0–2; cycle 3 stallM=0, ackM=1, misalignM=0; mem[4]=0xDEADBEEF after the cycle-3 edge; ackM=0 in cycle 4.
2. Load 0x10 after scenario 1 -> in cycle 3 of the access readdataM=0xDEADBEEF, ackM=1. Load 0x110 (alias, DEPTH 64) -> 0xDEADBEEF.
3. Misaligned store of 0x12345678 to 0x12 -> ackM=1 and misalignM=1 in cycle 3. A subsequent load of 0x10 returns 0xDEADBEEF. A misaligned load of 0x13 returns readdataM=0 with misalignM=1.
4. Back-to-back: two consecutive loads (0x10 then 0x14, the second presented the cycle after the first ack) -> each stalls 3 cycles; ackM pulses in cycles 3 and 7; no extra ack.
5. Store 0xCAFEF00D to 0x20 (previously 0x11111111), reset asserted in cycle 1 (WAIT) -> IDLE, ackM=0, readdataM=0 after the edge; a later load of 0x20 returns 0x11111111.
6. LATENCY=0 instance. Load request -> stallM=1 in cycle 0 only; ackM=1 with valid data in cycle 1. memreqM=0 throughout -> stallM=0 and ackM=0 permanently.
